hb_pwm_gen: RTL and testbench

// - Parametrised multi-channel H-bridge/VSI PWM generator with on-chip prescaler, carrier and interrupt timebase.
// - Produces NCH complementary gate pairs (s/nots) with tick-based dead time and period-synchronous duty reload.
// - Sits between the control core, which supplies duty words and services clk_int, and the inverter gate drivers.

---
 rtl/hb_pwm_gen.sv | 108 ++++++++++
 tb/tb_hb_pwm_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/hb_pwm_gen.sv
// hb_pwm_gen: multi-channel complementary PWM with prescaler, dead time, period-synchronous duty reload and interrupt timebase.
// Define HB_FAULT_EN to add the fault_n input with a latched gate shutdown.
module hb_pwm_gen #(
    parameter int PRESC   = 600,
    parameter int DW      = 10,
    parameter int NCH     = 2,
    parameter int DT      = 4,
    parameter int INT_DIV = 10,
    parameter int INT_HI  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic [NCH*DW-1:0] duty,
`ifdef HB_FAULT_EN
    input  logic              fault_n,
    output logic              fault_latched,
`endif
    output logic [NCH-1:0]    s,
    output logic [NCH-1:0]    nots,
    output logic              clk_int,
    output logic              period_start
);
    localparam int PW = PRESC > 1 ? $clog2(PRESC) : 1;
    localparam int CW = DT > 0 ? $clog2(DT + 1) : 1;
    localparam int IW = $clog2(INT_DIV);

    logic [PW-1:0]  pre_cnt;
    logic [DW-1:0]  car;
    logic [DW-1:0]  shadow [NCH];
    logic [CW-1:0]  cnt [NCH];
    logic [CW-1:0]  cnt_n [NCH];
    logic [NCH-1:0] raw, raw_q, s_n, n_n;
    logic [IW-1:0]  int_cnt, int_nxt;
    logic           tick, wrap, flt;

    assign tick    = ce && pre_cnt == PW'(PRESC - 1);
    assign wrap    = tick && car == '1;
    assign int_nxt = int_cnt == IW'(INT_DIV - 1) ? '0 : int_cnt + 1'b1;

`ifdef HB_FAULT_EN
    logic [1:0] fsync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsync         <= 2'b11;
            fault_latched <= 1'b0;
        end else begin
            fsync         <= {fsync[0], fault_n};
            fault_latched <= fault_latched | ~fsync[1];
        end
    end
    assign flt = ~fsync[1] | fault_latched;
`else
    assign flt = 1'b0;
`endif

    // the level counter restarts at 0 on each raw change, so a level must persist past DT ticks to drive a gate
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            raw[i]   = car < shadow[i];
            cnt_n[i] = raw[i] != raw_q[i] ? '0 : cnt[i] >= CW'(DT) ? CW'(DT) : cnt[i] + 1'b1;
            s_n[i]   = raw[i] && cnt_n[i] >= CW'(DT);
            n_n[i]   = !raw[i] && cnt_n[i] >= CW'(DT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt      <= '0;
            car          <= '0;
            int_cnt      <= '0;
            clk_int      <= 1'b0;
            period_start <= 1'b0;
            raw_q        <= '0;
            s            <= '0;
            nots         <= '0;
            for (int i = 0; i < NCH; i++) begin
                shadow[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            period_start <= wrap;
            if (ce)
                pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                car   <= car + 1'b1;
                raw_q <= raw;
                s     <= s_n;
                nots  <= n_n;
                for (int i = 0; i < NCH; i++)
                    cnt[i] <= flt ? '0 : cnt_n[i];
            end
            if (wrap) begin
                int_cnt <= int_nxt;
                clk_int <= int_nxt < IW'(INT_HI);
                for (int i = 0; i < NCH; i++)
                    shadow[i] <= duty[i*DW +: DW];
            end
            // shutdown overrides tick/ce gating
            if (flt) begin
                s    <= '0;
                nots <= '0;
                for (int i = 0; i < NCH; i++)
                    cnt[i] <= '0;
            end
        end
    end
endmodule

// File: tb/tb_hb_pwm_gen.sv
// tb_hb_pwm_gen: directed bench for hb_pwm_gen with PRESC=2, DW=4, NCH=2, DT=1, INT_DIV=10, INT_HI=5.
module tb_hb_pwm_gen;
    logic       clk = 1'b0, rst_n = 1'b0, ce = 1'b0;
    logic [7:0] duty = 8'hF8;
    logic [1:0] s, nots;
    logic       clk_int, period_start;
`ifdef HB_FAULT_EN
    logic       fault_n = 1'b1, fault_latched;
`endif
    int errs = 0, checks = 0, wraps = 0;
    int sc[2], nc[2], ov, pc, k, sor;

    always #5 clk = ~clk;

    hb_pwm_gen #(.PRESC(2), .DW(4), .NCH(2), .DT(1), .INT_DIV(10), .INT_HI(5)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .duty(duty),
`ifdef HB_FAULT_EN
        .fault_n(fault_n), .fault_latched(fault_latched),
`endif
        .s(s), .nots(nots), .clk_int(clk_int), .period_start(period_start));

    always @(negedge clk) begin
        if (!rst_n) wraps = 0;
        else if (period_start) wraps++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_ps(output int n, output int s_seen);
        n = 0;
        s_seen = 0;
        do begin
            @(negedge clk);
            n++;
            s_seen |= int'(|s);
        end while (!period_start && n < 200);
        chk("ps_timeout", period_start, 1);
        #1;
    endtask

    // samples one carrier period (16 ticks) starting at the period_start clock
    task automatic measure(input int wr_at, input logic [7:0] wr_val);
        int n, sx;
        wait_ps(n, sx);
        sc = '{0, 0};
        nc = '{0, 0};
        ov = 0;
        pc = 0;
        for (int j = 0; j < 16; j++) begin
            for (int c = 0; c < 2; c++) begin
                sc[c] += int'(s[c]);
                nc[c] += int'(nots[c]);
            end
            ov += int'(|(s & nots));
            if (j == wr_at) duty = wr_val;
            if (j < 15) repeat (2) begin
                @(negedge clk);
                pc += int'(period_start);
            end
        end
        chk("ps_once", pc, 0);
    endtask

    task automatic expect_w(input string tag, input int s0, input int n0, input int s1, input int n1);
        chk({tag, "_s0"}, sc[0], s0);
        chk({tag, "_n0"}, nc[0], n0);
        chk({tag, "_s1"}, sc[1], s1);
        chk({tag, "_n1"}, nc[1], n1);
        chk({tag, "_ovl"}, ov, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out", int'({s, nots, clk_int, period_start}), 0);
        rst_n = 1'b1;
        ce = 1'b1;
        measure(-1, 0);
        measure(-1, 0);
        expect_w("d8_15", 7, 7, 14, 0);
        duty = 8'hF0;
        measure(-1, 0);
        measure(-1, 0);
        expect_w("d0_15", 0, 16, 14, 0);
        duty = 8'h44;
        measure(-1, 0);
        measure(-1, 0);
        expect_w("d4", 3, 11, 3, 11);
        measure(6, 8'hCC);
        expect_w("rl_cur", 3, 11, 3, 11);
        measure(-1, 0);
        expect_w("rl_next", 11, 3, 11, 3);
        // freeze while both high sides are on (car=4, duty 12)
        wait_ps(k, sor);
        repeat (10) @(negedge clk);
        ce = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("frz", int'({s, nots, period_start}), 5'b11000);
        end
        ce = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!period_start && k < 100);
        chk("frz_resume", k, 22);
        #1;
        repeat (10) @(negedge clk);
        chk("pre_rst_s", int'(s), 3);
        rst_n = 1'b0;
        #1;
        chk("rst_async", int'({s, nots}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_t0", int'({s, nots}), 0);
        @(negedge clk);
        chk("rel_t1", int'({s, nots}), 4'b0011);
        chk("rel_int", int'(clk_int), 0);
        wait_ps(k, sor);
        chk("rel_first_s", sor, 0);
        chk("rel_first_ps", k, 30);
        chk("int_w1", int'(clk_int), 1);
        for (int p = 0; p < 20; p++) begin
            wait_ps(k, sor);
            chk("int_len", k, 32);
            chk("int_lvl", int'(clk_int), int'((wraps % 10) < 5));
        end
`ifdef HB_FAULT_EN
        repeat (10) @(negedge clk);
        chk("flt_pre", int'(s), 3);
        fault_n = 1'b0;
        @(negedge clk);
        fault_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("flt_off", int'({s, nots}), 0);
        chk("flt_latch", int'(fault_latched), 1);
        repeat (40) @(negedge clk);
        chk("flt_hold", int'({s, nots, fault_latched}), 1);
        rst_n = 1'b0;
        #1;
        chk("flt_clr", int'(fault_latched), 0);
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
